// File: rtl/branch_history_predictor.sv
// Dynamic branch predictor: a PC-indexed table of saturating counters for IF-stage
// lookup, plus EX-stage misprediction detection, rollback PC, training and statistics.
module branch_history_predictor #(
  parameter int ENTRIES    = 64,
  parameter int CNT_BITS   = 2,
  parameter int STAT_WIDTH = 16,
  parameter int MODE       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [31:0]           IF_PC_i,
  output logic                  predict_o,
  input  logic                  IDEX_Branch_i,
  input  logic                  IDEX_prediction_i,
  input  logic                  Zero_i,
  input  logic [31:0]           IDEX_PC_i,
  input  logic [31:0]           IDEX_immediate_i,
  output logic                  mispredict_o,
  output logic [31:0]           PC_rollback_o,
  output logic [STAT_WIDTH-1:0] branch_count_o,
  output logic [STAT_WIDTH-1:0] mispredict_count_o
);

  localparam int IDX = $clog2(ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  logic [CNT_BITS-1:0] table_q [ENTRIES];
  logic [IDX-1:0]      if_idx;
  logic [IDX-1:0]      ex_idx;
  logic [CNT_BITS-1:0] cur_cnt;
  logic [CNT_BITS-1:0] next_cnt;
  logic                unused_bits;

  // Word-aligned PCs: bits [1:0] never select an entry; high PC bits alias.
  assign if_idx = IF_PC_i[IDX+1:2];
  assign ex_idx = IDEX_PC_i[IDX+1:2];
  assign unused_bits = ^{IF_PC_i[31:IDX+2], IF_PC_i[1:0], IDEX_PC_i[31:IDX+2],
                         IDEX_PC_i[1:0], IDEX_immediate_i[31]};

  always_comb begin
    predict_o = 1'b0;
    if (MODE == 1) predict_o = table_q[if_idx][CNT_BITS-1];
  end

  assign mispredict_o  = IDEX_Branch_i & (IDEX_prediction_i ^ Zero_i);
  assign PC_rollback_o = IDEX_PC_i + ((IDEX_Branch_i & Zero_i) ?
                         {IDEX_immediate_i[30:0], 1'b0} : 32'd4);

  always_comb begin
    cur_cnt  = table_q[ex_idx];
    next_cnt = cur_cnt;
    if (Zero_i) begin
      if (cur_cnt != CNT_MAX) next_cnt = cur_cnt + CNT_BITS'(1);
    end else begin
      if (cur_cnt != '0) next_cnt = cur_cnt - CNT_BITS'(1);
    end
  end

  // Table: reads see the pre-edge value, so a same-cycle lookup gets no bypass.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_RST;
    end else if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_RST;
    end else if (IDEX_Branch_i && (MODE == 1)) begin
      table_q[ex_idx] <= next_cnt;
    end
  end

  // Statistics are kept in both modes and stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_count_o     <= '0;
      mispredict_count_o <= '0;
    end else if (clear_i) begin
      branch_count_o     <= '0;
      mispredict_count_o <= '0;
    end else if (IDEX_Branch_i) begin
      if (branch_count_o != STAT_MAX)
        branch_count_o <= branch_count_o + STAT_WIDTH'(1);
      if (mispredict_o && (mispredict_count_o != STAT_MAX))
        mispredict_count_o <= mispredict_count_o + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_history_predictor.sv
// Bench for branch_history_predictor: a dynamic 16-bit-stat instance and a static
// 4-bit-stat instance share stimulus and are checked against a behavioural model.
module tb_branch_history_predictor;

  localparam int ENTRIES  = 64;
  localparam int CNT_BITS = 2;
  localparam int MAX_A    = 65535;
  localparam int MAX_B    = 15;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        clear;
  logic [31:0] if_pc;
  logic        branch;
  logic        pred_in;
  logic        zero;
  logic [31:0] ex_pc;
  logic [31:0] imm;

  logic        predict_a, mispredict_a, predict_b, mispredict_b;
  logic [31:0] rollback_a, rollback_b;
  logic [15:0] bc_a, mc_a;
  logic [3:0]  bc_b, mc_b;

  // Reference model: counter values as plain integers, statistics unbounded.
  int tbl [ENTRIES];
  int bc_m, mc_m;
  int n_cmp = 0;
  int n_err = 0;
  logic [0:0] exp_q [$];

  branch_history_predictor #(.ENTRIES(ENTRIES), .CNT_BITS(CNT_BITS), .STAT_WIDTH(16), .MODE(1)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear), .IF_PC_i(if_pc), .predict_o(predict_a),
    .IDEX_Branch_i(branch), .IDEX_prediction_i(pred_in), .Zero_i(zero), .IDEX_PC_i(ex_pc),
    .IDEX_immediate_i(imm), .mispredict_o(mispredict_a), .PC_rollback_o(rollback_a),
    .branch_count_o(bc_a), .mispredict_count_o(mc_a));

  branch_history_predictor #(.ENTRIES(ENTRIES), .CNT_BITS(CNT_BITS), .STAT_WIDTH(4), .MODE(0)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear), .IF_PC_i(if_pc), .predict_o(predict_b),
    .IDEX_Branch_i(branch), .IDEX_prediction_i(pred_in), .Zero_i(zero), .IDEX_PC_i(ex_pc),
    .IDEX_immediate_i(imm), .mispredict_o(mispredict_b), .PC_rollback_o(rollback_b),
    .branch_count_o(bc_b), .mispredict_count_o(mc_b));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic model_pred(input logic [31:0] pc);
    return (tbl[idx_of(pc)] >= (2 ** (CNT_BITS - 1)));
  endfunction

  function automatic logic [31:0] model_rollback();
    if (branch && zero) return ex_pc + imm * 2;
    return ex_pc + 32'd4;
  endfunction

  function automatic int cap(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) tbl[i] = 2 ** (CNT_BITS - 1) - 1;
    bc_m = 0;
    mc_m = 0;
  endtask

  task automatic model_edge();
    int k;
    if (clear) begin
      model_reset();
    end else if (branch) begin
      bc_m++;
      if (pred_in != zero) mc_m++;
      k = idx_of(ex_pc);
      if (zero && tbl[k] < 2 ** CNT_BITS - 1) tbl[k]++;
      if (!zero && tbl[k] > 0) tbl[k]--;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    clear = 0; branch = 0; pred_in = 0; zero = 0;
  endtask

  task automatic drive_resolve(input logic [31:0] pc, input logic tk, input logic pr,
                               input logic [31:0] im);
    branch = 1; ex_pc = pc; zero = tk; pred_in = pr; imm = im;
  endtask

  task automatic do_clear();
    drive_idle();
    clear = 1;
    tick();
    clear = 0;
  endtask

  task automatic check_counts(input string tag);
    n_cmp++;
    if (bc_a !== 16'(cap(bc_m, MAX_A)) || mc_a !== 16'(cap(mc_m, MAX_A))) begin
      n_err++;
      $display("FAIL %s counts_a: got %0d/%0d want %0d/%0d", tag, bc_a, mc_a,
               cap(bc_m, MAX_A), cap(mc_m, MAX_A));
    end
    n_cmp++;
    if (bc_b !== 4'(cap(bc_m, MAX_B)) || mc_b !== 4'(cap(mc_m, MAX_B))) begin
      n_err++;
      $display("FAIL %s counts_b: got %0d/%0d want %0d/%0d", tag, bc_b, mc_b,
               cap(bc_m, MAX_B), cap(mc_m, MAX_B));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 0; drive_idle(); if_pc = 32'h40; ex_pc = 0; imm = 0;
    model_reset();
    #12;
    n_cmp++;
    if (predict_a !== 1'b0 || predict_b !== 1'b0) begin
      n_err++; $display("FAIL reset_predict: got %b/%b want 0/0", predict_a, predict_b);
    end
    check_counts("reset");
    drive_resolve(32'h100, 1'b1, 1'b0, 32'h10);
    #1;
    n_cmp++;
    if (mispredict_a !== 1'b1 || rollback_a !== 32'h120) begin
      n_err++; $display("FAIL reset_comb: got %b/%h want 1/00000120", mispredict_a, rollback_a);
    end
    drive_idle();
    @(posedge clk); #1;
    rst_i = 1;
  endtask

  task automatic test_lookup();
    if_pc = 32'h40;
    drive_resolve(32'h40, 1'b1, 1'b0, 32'd8);
    #1;
    n_cmp++;
    if (predict_a !== 1'b0) begin
      n_err++; $display("FAIL lookup_predict: got %b want 0", predict_a);
    end
    n_cmp++;
    if (mispredict_a !== 1'b1 || rollback_a !== 32'h50) begin
      n_err++; $display("FAIL lookup_resolve: got %b/%h want 1/00000050", mispredict_a, rollback_a);
    end
    drive_idle();
    #1;
    n_cmp++;
    if (mispredict_a !== 1'b0 || rollback_a !== 32'h44) begin
      n_err++; $display("FAIL lookup_idle: got %b/%h want 0/00000044", mispredict_a, rollback_a);
    end
    check_counts("lookup");
  endtask

  task automatic test_training();
    logic exp_p;
    if_pc = 32'h40;
    for (int i = 0; i < 8; i++) begin
      drive_resolve(32'h40, (i < 5), 1'b0, 32'd4);
      tick();
      exp_p = model_pred(32'h40);
      n_cmp++;
      if (predict_a !== exp_p) begin
        n_err++; $display("FAIL training_step%0d: got %b want %b", i, predict_a, exp_p);
      end
    end
    drive_idle();
    if_pc = 32'h44;
    #1;
    n_cmp++;
    if (predict_a !== 1'b0 || tbl[idx_of(32'h44)] != 1) begin
      n_err++; $display("FAIL training_neighbour: got %b want 0", predict_a);
    end
    check_counts("training");
  endtask

  task automatic test_alias_wrap();
    do_clear();
    for (int i = 0; i < 2; i++) begin
      drive_resolve(32'h100, 1'b1, 1'b1, 32'd0);
      tick();
    end
    drive_idle();
    if_pc = 32'h200;
    #1;
    n_cmp++;
    if (predict_a !== 1'b1) begin
      n_err++; $display("FAIL alias_predict: got %b want 1", predict_a);
    end
    drive_resolve(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h1234);
    #1;
    n_cmp++;
    if (rollback_a !== 32'h0 || mispredict_a !== 1'b0) begin
      n_err++; $display("FAIL wrap_rollback: got %h/%b want 00000000/0", rollback_a, mispredict_a);
    end
    drive_resolve(32'hFFFF_FFF0, 1'b1, 1'b1, 32'h0000_0010);
    #1;
    n_cmp++;
    if (rollback_a !== 32'h10) begin
      n_err++; $display("FAIL wrap_taken: got %h want 00000010", rollback_a);
    end
    tick();
    drive_idle();
    check_counts("alias");
  endtask

  task automatic test_same_cycle_clear();
    do_clear();
    if_pc = 32'h80;
    drive_resolve(32'h80, 1'b1, 1'b0, 32'd2);
    #1;
    n_cmp++;
    if (predict_a !== 1'b0) begin
      n_err++; $display("FAIL same_cycle_before: got %b want 0", predict_a);
    end
    tick();
    drive_idle();
    n_cmp++;
    if (predict_a !== 1'b1) begin
      n_err++; $display("FAIL same_cycle_after: got %b want 1", predict_a);
    end
    drive_resolve(32'h80, 1'b1, 1'b0, 32'd2);
    clear = 1;
    tick();
    drive_idle();
    n_cmp++;
    if (predict_a !== 1'b0 || bc_a !== 16'd0 || mc_a !== 16'd0) begin
      n_err++; $display("FAIL clear_priority: got %b/%0d/%0d want 0/0/0", predict_a, bc_a, mc_a);
    end
    drive_resolve(32'h80, 1'b1, 1'b0, 32'd2);
    tick();
    drive_idle();
    n_cmp++;
    if (predict_a !== 1'b1) begin
      n_err++; $display("FAIL clear_entry_value: got %b want 1", predict_a);
    end
    check_counts("clear");
  endtask

  task automatic test_stat_saturation();
    do_clear();
    if_pc = 32'h300;
    for (int i = 0; i < 20; i++) begin
      drive_resolve(32'h300, 1'b1, 1'b0, 32'd6);
      tick();
      n_cmp++;
      if (predict_b !== 1'b0) begin
        n_err++; $display("FAIL static_predict%0d: got %b want 0", i, predict_b);
      end
    end
    drive_idle();
    n_cmp++;
    if (bc_b !== 4'd15 || mc_b !== 4'd15 || bc_a !== 16'd20 || mc_a !== 16'd20) begin
      n_err++; $display("FAIL stat_saturation: got %0d/%0d/%0d/%0d want 15/15/20/20",
                        bc_b, mc_b, bc_a, mc_a);
    end
    check_counts("stat_sat");
  endtask

  task automatic test_random();
    logic exp_p;
    for (int i = 0; i < 300; i++) begin
      clear   = ($urandom_range(0, 40) == 0);
      branch  = ($urandom_range(0, 3) != 0);
      zero    = 1'($urandom_range(0, 1));
      pred_in = 1'($urandom_range(0, 1));
      ex_pc   = {$urandom_range(0, 1) ? 24'hFFFFFF : 24'h0, 8'($urandom_range(0, 63) * 4)} |
                32'($urandom_range(0, 3));
      if_pc   = 32'($urandom_range(0, 63) * 4);
      imm     = $urandom;
      #1;
      exp_q.push_back(model_pred(if_pc));
      exp_p = exp_q.pop_front();
      n_cmp++;
      if (predict_a !== exp_p || predict_b !== 1'b0) begin
        n_err++; $display("FAIL random_predict%0d: got %b/%b want %b/0", i, predict_a, predict_b, exp_p);
      end
      n_cmp++;
      if (mispredict_a !== (branch && (pred_in != zero)) || mispredict_b !== mispredict_a ||
          rollback_a !== model_rollback() || rollback_b !== rollback_a) begin
        n_err++; $display("FAIL random_resolve%0d: got %b/%h want %b/%h", i, mispredict_a,
                          rollback_a, (branch && (pred_in != zero)), model_rollback());
      end
      tick();
      check_counts("random");
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    do_clear();
    if_pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      drive_resolve(32'h40, 1'b1, 1'b0, 32'd0);
      tick();
    end
    drive_idle();
    n_cmp++;
    if (predict_a !== 1'b1 || bc_a !== 16'd3) begin
      n_err++; $display("FAIL async_pretrain: got %b/%0d want 1/3", predict_a, bc_a);
    end
    #2;
    rst_i = 0;
    model_reset();
    #1;
    n_cmp++;
    if (predict_a !== 1'b0) begin
      n_err++; $display("FAIL async_predict: got %b want 0", predict_a);
    end
    check_counts("async");
    #1;
    rst_i = 1;
    drive_resolve(32'h40, 1'b1, 1'b0, 32'd0);
    tick();
    drive_idle();
    n_cmp++;
    if (predict_a !== 1'b1 || bc_a !== 16'd1) begin
      n_err++; $display("FAIL post_reset_update: got %b/%0d want 1/1", predict_a, bc_a);
    end
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_training();
    test_alias_wrap();
    test_same_cycle_clear();
    test_stat_saturation();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
